// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite definitions: transfer/size/burst encodings, response
// constants, the SRAM slave state enum and a byte-lane helper.
// Used by ahb_sram_slave and ahb_sram_mem.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'b000,
        SIZE_HALF   = 3'b001,
        SIZE_WORD   = 3'b010,
        SIZE_DWORD  = 3'b011,
        SIZE_4WORD  = 3'b100,
        SIZE_8WORD  = 3'b101,
        SIZE_16WORD = 3'b110,
        SIZE_32WORD = 3'b111
    } hsize_type;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_slv_state_type;

    // Little-endian byte-lane enables for a transfer. Address bits below the
    // transfer size are ignored, and anything wider than a half is a word.
    function automatic logic [3:0] lane_mask(input hsize_type size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << addr;
            SIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// ahb_sram_mem: DEPTH x 32-bit storage with a per-byte write enable and an
// asynchronous read port. Read and write share one word address, which the
// slave supplies from its registered address phase.
module ahb_sram_mem
    import AHB_package::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          hclk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write; only the enabled lanes of the addressed word change.
    // NOTE: the array has no reset branch on purpose; clearing every word would
    // turn a plain RAM into a huge register file, and contents need not survive reset.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a single-port SRAM.
// Optional macro AHB_SLAVE_ERR_EN enables ERROR responses for out-of-range,
// oversize and misaligned transfers; without it hresp is tied to OKAY,
// addresses wrap modulo DEPTH and oversize transfers act as word transfers.
// DEPTH is expected to be a power of two.
module ahb_sram_slave
    import AHB_package::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  hsize_type   hsize,
    input  hburst_type  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  htrans_type  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int AW = $clog2(DEPTH);

    ahb_slv_state_type state;
    logic [31:0]       addr_q;
    logic              write_q;
    hsize_type         size_q;
    logic [2:0]        wait_cnt;
    logic              ready_q;
    logic              resp_q;

    logic              accept;
    logic              bad_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    assign accept = hsel && hready && (htrans == NONSEQ || htrans == SEQ);

    // Classify the address phase being offered as legal or as an error request.
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        bad_req = 1'b0;
`ifdef AHB_SLAVE_ERR_EN
        if (haddr >= 32'(DEPTH * 4))                        bad_req = 1'b1;
        if (hsize > SIZE_WORD)                              bad_req = 1'b1;
        if (hsize == SIZE_HALF && haddr[0])                 bad_req = 1'b1;
        if (hsize == SIZE_WORD && haddr[1:0] != 2'b00)      bad_req = 1'b1;
`endif
    end

    // Transfer FSM: captures the address phase and registers hreadyout/hresp.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            resp_q   <= OKAY;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= SIZE_BYTE;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
`ifdef AHB_SLAVE_ERR_EN
                // First error cycle: stall while signalling ERROR; new requests are ignored.
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= ERROR;
                end
`endif
                // ST_IDLE, ST_DATA and ST_ERR2 all end with hreadyout high, so a
                // new address phase may be accepted on this edge.
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= OKAY;
                    if (accept) begin
                        addr_q  <= haddr;
                        write_q <= hwrite;
                        size_q  <= hsize;
                        if (bad_req) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            ready_q  <= 1'b0;
                            wait_cnt <= 3'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
            endcase
        end
    end

    // Write commits as the data phase completes; a reset on that edge discards it.
    assign mem_we = (state == ST_DATA) && write_q && !hreset;
    assign mem_be = lane_mask(size_q, addr_q[1:0]);

    ahb_sram_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .hclk  (hclk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    // The asynchronous read sees a write committed on the previous edge, so a
    // read immediately following a write returns the new data without a stall.
    assign hrdata    = (state == ST_DATA && !write_q) ? mem_rdata : 32'h0;
    assign hreadyout = ready_q;

`ifdef AHB_SLAVE_ERR_EN
    assign hresp = resp_q;
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, addr_q[31:AW+2]};
`else
    assign hresp = OKAY;
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, addr_q[31:AW+2], resp_q};
`endif

endmodule
